freq_synth: RTL and testbench



---
 rtl/freq_synth_pkg.sv | 20 ++
 rtl/freq_synth_divider.sv | 111 +++++++++++
 rtl/freq_synth.sv | 196 +++++++++++++++++++
 tb/tb_freq_synth.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/freq_synth_pkg.sv
// freq_synth_pkg: shared definitions for the programmable square-wave generator.
//   - state_t     : sequencer states (IDLE, CONV, DIV, RUN)
//   - *_DEF       : default values for the CLK_HZ / DIV_W / FREQ_W parameters
//   - BCD_MAX     : largest legal BCD digit
package freq_synth_pkg;

  localparam int CLK_HZ_DEF = 50000000;
  localparam int DIV_W_DEF  = 26;
  localparam int FREQ_W_DEF = 17;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DIV  = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/freq_synth_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             begin a division (performs the first iteration on this edge)
//   abort             cancel any division in progress (priority over start)
//   dividend[DIV_W]   numerator, sampled on start
//   divisor[FREQ_W]   denominator, sampled on start (must be non-zero)
//   quotient[DIV_W]   truncated quotient, valid while done is high
//   done              one-cycle pulse, DIV_W cycles after start was sampled
module seq_divider
  import freq_synth_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIV_W-1:0]  dividend,
  input  logic [FREQ_W-1:0] divisor,
  output logic [DIV_W-1:0]  quotient,
  output logic              done
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0]  dvd_r;
  logic [FREQ_W-1:0] dsr_r;
  logic [FREQ_W-1:0] rem_r;
  logic [DIV_W-1:0]  quo_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              active_r;
  logic              done_r;

  logic              bit_s;
  logic [FREQ_W-1:0] rem_in_s;
  logic [FREQ_W-1:0] dsr_in_s;
  logic [FREQ_W:0]   trial_s;
  logic [FREQ_W:0]   diff_s;
  logic              ge_s;
  logic [FREQ_W-1:0] rem_nx_s;

  // One restoring step; on start the operands come straight from the ports
  // so the first quotient bit is produced on the start edge itself.
  always_comb begin
    bit_s    = 1'b0;
    rem_in_s = '0;
    dsr_in_s = '0;
    if (start) begin
      bit_s    = dividend[DIV_W-1];
      rem_in_s = '0;
      dsr_in_s = divisor;
    end else begin
      bit_s    = dvd_r[DIV_W-1];
      rem_in_s = rem_r;
      dsr_in_s = dsr_r;
    end
    // The remainder is always below the divisor, so FREQ_W+1 bits hold the shifted value.
    trial_s = {rem_in_s, bit_s};
    diff_s  = trial_s - {1'b0, dsr_in_s};
    ge_s    = (trial_s >= {1'b0, dsr_in_s});
    if (ge_s) begin
      rem_nx_s = diff_s[FREQ_W-1:0];
    end else begin
      rem_nx_s = trial_s[FREQ_W-1:0];
    end
  end

  // Iteration registers: dividend shifter, remainder, quotient, step counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r    <= '0;
      dsr_r    <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else if (abort) begin
      cnt_r    <= '0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      dvd_r    <= {dividend[DIV_W-2:0], 1'b0};
      dsr_r    <= divisor;
      rem_r    <= rem_nx_s;
      quo_r    <= {{(DIV_W-1){1'b0}}, ge_s};
      cnt_r    <= CNT_W'(1);
      active_r <= 1'b1;
      done_r   <= 1'b0;
    end else if (active_r) begin
      dvd_r <= {dvd_r[DIV_W-2:0], 1'b0};
      rem_r <= rem_nx_s;
      quo_r <= {quo_r[DIV_W-2:0], ge_s};
      cnt_r <= cnt_r + CNT_W'(1);
      if (cnt_r == CNT_W'(DIV_W - 1)) begin
        active_r <= 1'b0;
        done_r   <= 1'b1;
      end else begin
        done_r   <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign quotient = quo_r;
  assign done     = done_r;

endmodule

// File: rtl/freq_synth.sv
// freq_synth: programmable square-wave generator.
// A 4-digit BCD setpoint (optionally x10) is converted to binary, the half-period
// CLK_HZ/2 / f is computed by seq_divider, and sigout toggles every half_q cycles.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   load                  single-cycle strobe capturing bcd3..bcd0 and range
//   bcd3..bcd0            thousands..units digits
//   range                 0: f = BCD value, 1: f = BCD value x10
//   sigout                square wave output (starts low)
//   busy                  high while converting/dividing
//   err                   sticky until next load; a captured digit was > 9
//   half_q[DIV_W]         current half-period in clk cycles, 0 when stopped
module freq_synth
  import freq_synth_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd0,
  input  logic             range,
  output logic             sigout,
  output logic             busy,
  output logic             err,
  output logic [DIV_W-1:0] half_q
);

  localparam logic [DIV_W-1:0] HALF_CLK = DIV_W'(CLK_HZ / 2);

  state_t            state_r, state_nx;
  logic [3:0]        d3_r, d2_r, d1_r, d0_r;
  logic              range_r;
  logic              sig_r, sig_nx;
  logic              busy_r, busy_nx;
  logic              err_r, err_nx;
  logic [DIV_W-1:0]  half_r, half_nx;
  logic [DIV_W-1:0]  cnt_r, cnt_nx;

  logic              bad_in_s;
  logic              zero_in_s;
  logic [FREQ_W-1:0] freq_s;
  logic              div_start_s;
  logic              div_done_s;
  logic [DIV_W-1:0]  div_quo_s;

  assign bad_in_s  = (bcd3 > BCD_MAX) | (bcd2 > BCD_MAX) | (bcd1 > BCD_MAX) | (bcd0 > BCD_MAX);
  assign zero_in_s = ({bcd3, bcd2, bcd1, bcd0} == 16'd0);

  // Horner-form BCD to binary on the captured digits; stable between loads.
  always_comb begin
    freq_s = FREQ_W'(d3_r);
    freq_s = freq_s * FREQ_W'(4'd10) + FREQ_W'(d2_r);
    freq_s = freq_s * FREQ_W'(4'd10) + FREQ_W'(d1_r);
    freq_s = freq_s * FREQ_W'(4'd10) + FREQ_W'(d0_r);
    if (range_r) begin
      freq_s = freq_s * FREQ_W'(4'd10);
    end else begin
      freq_s = freq_s;
    end
  end

  // The divider is kicked from CONV; a load in the same cycle cancels it instead.
  assign div_start_s = (state_r == CONV) && !load;

  seq_divider #(
    .DIV_W (DIV_W),
    .FREQ_W(FREQ_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start_s),
    .abort   (load),
    .dividend(HALF_CLK),
    .divisor (freq_s),
    .quotient(div_quo_s),
    .done    (div_done_s)
  );

  // Setpoint capture register, written only by load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d3_r    <= 4'd0;
      d2_r    <= 4'd0;
      d1_r    <= 4'd0;
      d0_r    <= 4'd0;
      range_r <= 1'b0;
    end else if (load) begin
      d3_r    <= bcd3;
      d2_r    <= bcd2;
      d1_r    <= bcd1;
      d0_r    <= bcd0;
      range_r <= range;
    end else begin
      d3_r    <= d3_r;
      d2_r    <= d2_r;
      d1_r    <= d1_r;
      d0_r    <= d0_r;
      range_r <= range_r;
    end
  end

  // Sequencer next-state and output logic; load overrides every state.
  always_comb begin
    state_nx = state_r;
    sig_nx   = sig_r;
    busy_nx  = busy_r;
    err_nx   = err_r;
    half_nx  = half_r;
    cnt_nx   = cnt_r;
    if (load) begin
      sig_nx  = 1'b0;
      half_nx = '0;
      cnt_nx  = '0;
      err_nx  = 1'b0;
      if (bad_in_s) begin
        err_nx   = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end else if (zero_in_s) begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end else begin
        busy_nx  = 1'b1;
        state_nx = CONV;
      end
    end else begin
      case (state_r)
        IDLE: begin
          sig_nx  = 1'b0;
          cnt_nx  = '0;
          busy_nx = 1'b0;
        end
        CONV: begin
          busy_nx  = 1'b1;
          state_nx = DIV;
        end
        DIV: begin
          if (div_done_s) begin
            half_nx  = div_quo_s;
            cnt_nx   = '0;
            busy_nx  = 1'b0;
            state_nx = RUN;
          end else begin
            busy_nx  = 1'b1;
          end
        end
        RUN: begin
          if (cnt_r == half_r - DIV_W'(1)) begin
            cnt_nx = '0;
            sig_nx = ~sig_r;
          end else begin
            cnt_nx = cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          sig_nx   = 1'b0;
          busy_nx  = 1'b0;
          half_nx  = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      sig_r   <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      half_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      sig_r   <= sig_nx;
      busy_r  <= busy_nx;
      err_r   <= err_nx;
      half_r  <= half_nx;
      cnt_r   <= cnt_nx;
    end
  end

  assign sigout = sig_r;
  assign busy   = busy_r;
  assign err    = err_r;
  assign half_q = half_r;

endmodule

// File: tb/tb_freq_synth.sv
`timescale 1ns/1ps
// tb_freq_synth: directed bench for freq_synth with hand-computed half-periods
// (25 000 000 / f, truncated) and measured sigout timing.
module tb_freq_synth;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
  logic        range = 1'b0;
  logic        sigout, busy, err;
  logic [25:0] half_q;

  int n_cmp  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  freq_synth dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bcd3  (bcd3),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0),
    .range (range),
    .sigout(sigout),
    .busy  (busy),
    .err   (err),
    .half_q(half_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse load for one cycle, then scramble the inputs (they must be ignored).
  task automatic do_load(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input logic r);
    @(negedge clk);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0; range = r;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcd3 = 4'hF; bcd2 = 4'h7; bcd1 = 4'h3; bcd0 = 4'h1; range = ~r;
  endtask

  // Called right after do_load: busy must last 1+26 cycles, then half_q holds the quotient.
  task automatic wait_quotient(input string tag, input int exp_half);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(n), 32'd27);
    check({tag, " half_q"}, 32'(half_q), 32'(exp_half));
  endtask

  // Called on RUN entry: first rise after h cycles, then a full period of 2h.
  task automatic measure(input string tag, input int h);
    int n;
    int lim;
    lim = 3 * h + 100;
    n = 0;
    while (sigout !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, " first rise"}, 32'(n), 32'(h));
    n = 0;
    while (sigout === 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    while (sigout !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, " period"}, 32'(n), 32'(2 * h));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst sigout", 32'(sigout), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst half_q", 32'(half_q), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 3125 Hz -> 8000
    do_load(4'd3, 4'd1, 4'd2, 4'd5, 1'b0);
    check("3125 half_q during busy", 32'(half_q), 32'd0);
    wait_quotient("3125", 8000);
    measure("3125", 8000);

    // 6250 Hz -> 4000; load while sigout high forces it low
    do_load(4'd6, 4'd2, 4'd5, 4'd0, 1'b0);
    check("6250 sigout forced low", 32'(sigout), 32'd0);
    check("6250 half_q cleared", 32'(half_q), 32'd0);
    wait_quotient("6250", 4000);
    measure("6250", 4000);

    // 50 Hz -> 500000 (too slow to measure the period here)
    do_load(4'd0, 4'd0, 4'd5, 4'd0, 1'b0);
    wait_quotient("0050", 500000);

    // 2500 x10 = 25000 Hz -> 1000
    do_load(4'd2, 4'd5, 4'd0, 4'd0, 1'b1);
    wait_quotient("25000", 1000);
    measure("25000", 1000);

    // 312 0 x10 = 31200 Hz -> 801 (truncated)
    do_load(4'd3, 4'd1, 4'd2, 4'd0, 1'b1);
    wait_quotient("31200", 801);
    measure("31200", 801);

    // Invalid digit while sigout is high
    do_load(4'd3, 4'hA, 4'd2, 4'd0, 1'b0);
    check("bad err", 32'(err), 32'd1);
    check("bad sigout", 32'(sigout), 32'd0);
    check("bad half_q", 32'(half_q), 32'd0);
    check("bad busy", 32'(busy), 32'd0);
    repeat (50) @(negedge clk);
    check("bad err sticky", 32'(err), 32'd1);
    check("bad still idle", 32'(busy), 32'd0);

    // Valid load clears err; then stop with 0000 while running at 50 Hz
    do_load(4'd0, 4'd0, 4'd5, 4'd0, 1'b0);
    check("err cleared", 32'(err), 32'd0);
    wait_quotient("50Hz", 500000);
    repeat (100) @(negedge clk);
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    check("stop sigout", 32'(sigout), 32'd0);
    check("stop half_q", 32'(half_q), 32'd0);
    check("stop err", 32'(err), 32'd0);
    check("stop busy", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    check("stop idle busy", 32'(busy), 32'd0);
    check("stop idle half_q", 32'(half_q), 32'd0);

    // Reset in the middle of DIV
    do_load(4'd3, 4'd1, 4'd2, 4'd5, 1'b0);
    repeat (10) @(negedge clk);
    check("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid-rst busy", 32'(busy), 32'd0);
    check("mid-rst half_q", 32'(half_q), 32'd0);
    check("mid-rst sigout", 32'(sigout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post-rst busy", 32'(busy), 32'd0);
    check("post-rst half_q", 32'(half_q), 32'd0);

    // New load in the middle of DIV restarts the sequence
    do_load(4'd6, 4'd2, 4'd5, 4'd0, 1'b0);
    repeat (10) @(negedge clk);
    do_load(4'd2, 4'd5, 4'd0, 4'd0, 1'b1);
    wait_quotient("restart", 1000);

    // Load on the same edge as the final DIV step: old quotient is discarded
    do_load(4'd6, 4'd2, 4'd5, 4'd0, 1'b0);
    repeat (25) @(negedge clk);
    do_load(4'd3, 4'd1, 4'd2, 4'd0, 1'b1);
    check("late load half_q", 32'(half_q), 32'd0);
    check("late load busy", 32'(busy), 32'd1);
    wait_quotient("late load", 801);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
